// File: rtl/cpu_defs.sv
// Shared control-unit/fetch definitions: next-PC select codes and vector addresses.
package cpu_defs;

    typedef enum logic [2:0] {
        PCSRC_SEQ = 3'd0,
        PCSRC_BR  = 3'd1,
        PCSRC_J   = 3'd2,
        PCSRC_JR  = 3'd3,
        PCSRC_EXC = 3'd4,
        PCSRC_IRQ = 3'd5
    } pcsrc_e;

    localparam logic [31:0] RESET_VEC_DEF = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC_DEF   = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC_DEF   = 32'h8000_0008;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    // Sign-extended word offset, already scaled to bytes, in the 31-bit address space.
    function automatic logic [30:0] br_offset(input logic [15:0] imm);
        return {{13{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_unit_irq_sync.sv
// Multi-flop synchroniser for the asynchronous interrupt line with rising-edge detect.
module irq_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter stage: PC register, next-PC mux and kernel-masked interrupt request.
module pc_fetch_unit
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_VEC   = RESET_VEC_DEF,
    parameter logic [31:0] IRQ_VEC     = IRQ_VEC_DEF,
    parameter logic [31:0] EXC_VEC     = EXC_VEC_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  pcsrc,
    input  logic        alu_zero,
    input  logic [15:0] imm16,
    input  logic [25:0] jt_addr,
    input  logic [31:0] jr_target,
    input  logic        irq_in,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] pc_link,
    output logic        irq_req
);

    logic [31:0] pc_q, pc_d;
    logic        pend_q, pend_d;
    logic        irq_rise;
    logic        irq_accept;

    irq_sync #(
        .STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk     (clk),
        .rst_n   (reset),
        .async_i (irq_in),
        .rise_o  (irq_rise)
    );

    assign pc       = pc_q;
    assign pc_plus4 = {pc_q[31], pc_q[30:0] + 31'd4};
    assign irq_req  = pend_q & ~pc_q[31];
    assign pc_link  = irq_req ? pc_q : pc_plus4;

    always_comb begin
        pc_d = pc_q;
        if (!stall) begin
            case (pcsrc)
                PCSRC_SEQ: pc_d = pc_plus4;
                PCSRC_BR:  pc_d = alu_zero ? {pc_q[31], pc_plus4[30:0] + br_offset(imm16)}
                                           : pc_plus4;
                PCSRC_J:   pc_d = {pc_plus4[31:28], jt_addr, 2'b00};
                // Kernel bit may only be kept, never gained, through a register jump.
                PCSRC_JR:  pc_d = {pc_q[31] & jr_target[31], jr_target[30:0]};
                PCSRC_IRQ: pc_d = IRQ_VEC;
                default:   pc_d = EXC_VEC;
            endcase
        end
    end

    // A fresh edge outranks acceptance so a back-to-back interrupt is never lost.
    assign irq_accept = irq_req & ~stall & (pcsrc == PCSRC_IRQ);
    assign pend_d     = irq_rise | (pend_q & ~irq_accept);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q   <= RESET_VEC;
            pend_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            pend_q <= pend_d;
        end
    end

endmodule
